// File: rtl/div_meter_pkg.sv
// -----------------------------------------------------------------------------
// div_meter_pkg
//
// Shared definitions for the divided-clock ratio meter and related clock
// checkers.
//
// Contents:
//   meter_state_e   - measurement FSM states (IDLE, SYNC, MEASURE)
//   DEF_CNT_W       - default width of period/high-time counters
//   DEF_MAX_RATIO   - default timeout, in source-clock cycles
//   DEF_STABLE_N    - default number of identical periods before valid
//
// Optional feature macro used by the meter: DIV_METER_DUTY_EN (high-time
// measurement). The package itself does not depend on it.
// -----------------------------------------------------------------------------
package div_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // waiting for start
        SYNC    = 2'd1,  // waiting for the first rising edge of div_in
        MEASURE = 2'd2   // locked, capturing one period per rising edge
    } meter_state_e;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_MAX_RATIO = 255;
    localparam int DEF_STABLE_N  = 2;

endpackage : div_meter_pkg

// File: rtl/div_edge_det.sv
// -----------------------------------------------------------------------------
// div_edge_det
//
// Rising-edge detector for a signal that is already synchronous to clk
// (no synchronizer stages). Reusable by any clock checker that samples a
// divided clock in its source domain.
//
// Ports:
//   clk     in  1  sampling clock
//   reset   in  1  asynchronous, active-low reset (clears the delay register)
//   sig_in  in  1  sampled signal, synchronous to clk
//   rise    out 1  combinational: sig_in is 1 this cycle and was 0 last cycle
// -----------------------------------------------------------------------------
module div_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);

    logic sig_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_d;

endmodule : div_edge_det

// File: rtl/div_ratio_meter.sv
// -----------------------------------------------------------------------------
// div_ratio_meter
//
// In-system checker for a divided clock produced by clk_div. Samples div_in
// in the source clock domain, locks onto its rising edges and reports the
// period (divide ratio) and high time in source-clock cycles. Flags a missing
// or stuck divided clock with a sticky timeout error.
//
// Parameters:
//   CNT_W      width of period/high-time counters and results
//   MAX_RATIO  timeout in clk cycles without a rising edge (<= 2**CNT_W-1)
//   STABLE_N   consecutive identical periods required before valid (>= 1)
//
// Ports:
//   clk       in  1      source clock feeding the divider
//   reset     in  1      asynchronous, active-low reset
//   start     in  1      one-cycle pulse, (re)starts measurement from any state
//   div_in    in  1      divided clock under test, synchronous to clk
//   ratio     out CNT_W  last measured period in clk cycles
//   high_cnt  out CNT_W  clk cycles div_in was high within that period
//   valid     out 1      ratio/high_cnt stable for STABLE_N periods
//   err       out 1      sticky timeout flag
//
// Build option:
//   DIV_METER_DUTY_EN  defined   -> high-time counter present, stability also
//                                   requires an unchanged high time
//                      undefined -> no high-time counter, high_cnt tied to 0
// -----------------------------------------------------------------------------
module div_ratio_meter
    import div_meter_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_RATIO = DEF_MAX_RATIO,
    parameter int STABLE_N  = DEF_STABLE_N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div_in,
    output logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] high_cnt,
    output logic             valid,
    output logic             err
);

    // Stability counter only needs to reach STABLE_N (it saturates there).
    localparam int STAB_W = (STABLE_N < 2) ? 1 : $clog2(STABLE_N + 1);

    localparam logic [CNT_W-1:0]  MAX_P    = CNT_W'(MAX_RATIO);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [STAB_W-1:0] STAB_N   = STAB_W'(STABLE_N);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

    // Saturating increment for the stability counter.
    function automatic logic [STAB_W-1:0] stab_sat_inc(input logic [STAB_W-1:0] v);
        if (v >= STAB_N) begin
            return STAB_N;
        end
        return v + STAB_ONE;
    endfunction

    meter_state_e      state;
    meter_state_e      state_next;

    logic              rise;
    logic              active;
    logic              timeout;
    logic              capture;
    logic              match;
    logic [STAB_W-1:0] stab_cnt;
    logic [STAB_W-1:0] stab_upd;

    logic [CNT_W-1:0]  per_cnt;
    logic [CNT_W-1:0]  ratio_q;
    logic              valid_q;
    logic              err_q;

    // -------------------------------------------------------------------------
    // Edge detection on the divided clock
    // -------------------------------------------------------------------------
    div_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (div_in),
        .rise   (rise)
    );

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    assign active  = (state == SYNC) || (state == MEASURE);
    // A rise on the cycle per_cnt sits at MAX_RATIO is still a valid capture;
    // only a missing rise at that point is a timeout. This keeps per_cnt from
    // ever exceeding MAX_RATIO, so the counters cannot wrap.
    assign timeout = active && (per_cnt == MAX_P) && !rise;
    assign capture = (state == MEASURE) && rise;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state (start overrides everything, including a coincident rise)
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = SYNC;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                SYNC: begin
                    if (timeout) begin
                        state_next = SYNC;
                    end else if (rise) begin
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (timeout) begin
                        state_next = SYNC;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Period counter: reloaded to 1 on the rise so that its value at the next
    // rise equals the cycle distance between the two rises.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_cnt <= '0;
        end else if (start || !active || timeout) begin
            per_cnt <= '0;
        end else if (rise) begin
            per_cnt <= CNT_ONE;
        end else begin
            per_cnt <= per_cnt + CNT_ONE;
        end
    end

`ifdef DIV_METER_DUTY_EN
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] high_q;

    // -------------------------------------------------------------------------
    // High-time counter: the rise cycle itself is high, hence the reload to 1.
    // It can never exceed per_cnt, so it inherits the no-wrap guarantee.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_cnt <= '0;
        end else if (start || !active || timeout) begin
            hi_cnt <= '0;
        end else if (rise) begin
            hi_cnt <= CNT_ONE;
        end else if ((state == MEASURE) && div_in) begin
            hi_cnt <= hi_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_q <= '0;
        end else if (capture && !start) begin
            high_q <= hi_cnt;
        end
    end

    assign match    = (per_cnt == ratio_q) && (hi_cnt == high_q);
    assign high_cnt = high_q;
`else
    assign match    = (per_cnt == ratio_q);
    assign high_cnt = '0;
`endif

    // -------------------------------------------------------------------------
    // Captured period and stability tracking
    // -------------------------------------------------------------------------
    assign stab_upd = match ? stab_sat_inc(stab_cnt) : STAB_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ratio_q <= '0;
        end else if (capture && !start) begin
            ratio_q <= per_cnt;
        end
    end

    // valid is registered together with ratio so it rises in the same cycle
    // as the STABLE_N-th matching capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stab_cnt <= '0;
            valid_q  <= 1'b0;
        end else if (start || timeout) begin
            stab_cnt <= '0;
            valid_q  <= 1'b0;
        end else if (capture) begin
            stab_cnt <= stab_upd;
            valid_q  <= (stab_upd >= STAB_N);
        end
    end

    // -------------------------------------------------------------------------
    // Sticky timeout flag, cleared only by start or reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (start) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign ratio = ratio_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule : div_ratio_meter

// File: doc/div_ratio_meter.md
# div_ratio_meter

Measures the divide ratio and high time of a divided clock produced by the clk_div block, sampling it in the source clock domain. Sits beside the divider as its in-system checker: it locks onto a divided output, reports period and high time in source-clock cycles, and flags a missing or unstable divided clock. Intended for self-check of clk_div2/3/4/6/8 in simulation and silicon bring-up.

## Interface
- CNT_W, 8: width of period/high-time counters and results
- MAX_RATIO, 255: timeout in clk cycles without a rising edge of div_in (must be ≤ 2**CNT_W − 1)
- STABLE_N, 2: consecutive identical periods required before `valid` asserts (≥ 1)
- clk  in  1  source clock, the clock that feeds the divider
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; (re)starts measurement from any state
- div_in  in  1  divided clock under test, synchronous to clk
- ratio  out  CNT_W  last measured period in clk cycles
- high_cnt  out  CNT_W  clk cycles div_in sampled high within that period
- valid  out  1  ratio/high_cnt stable for STABLE_N periods
- err  out  1  sticky timeout flag

## Operation
- Reset (reset=0): state IDLE; ratio=0, high_cnt=0, valid=0, err=0; counters and edge register cleared.
- Edge detect: div_d registers div_in each cycle; rise = div_in & ~div_d. div_in is synchronous; no synchronizer.
- States: IDLE → (start) → SYNC → (rise) → MEASURE; MEASURE → MEASURE on each rise; SYNC or MEASURE → SYNC on timeout.
- start in any state: go to SYNC, clear valid, err, stable count; ratio/high_cnt hold.
- SYNC: per_cnt counts cycles; first rise loads per_cnt=1, high counter=1, enters MEASURE.
- MEASURE: per_cnt +1 per cycle; high counter +1 per cycle with div_in=1. On rise: capture period = per_cnt value at the rise (cycle distance between consecutive rises) and high time, reload counters as in SYNC.
- Stability: captured period equal to previous capture → stable count +1 (saturating at STABLE_N); differing → stable count=1, valid=0. valid=1 while stable count ≥ STABLE_N.
- Timeout: per_cnt reaching MAX_RATIO without a rise → err=1, valid=0, state SYNC. err sticky until start or reset.
- Minimum measurable ratio is 2; a constant div_in (0 or 1) yields timeout.
- Counters never wrap: the timeout fires before CNT_W overflow.
- start coincident with a rise: start wins (SYNC, that rise not used).

## Timing
- ratio/high_cnt update one clk cycle after the sampling edge at which rise is seen.
- valid asserts in the same cycle as the STABLE_N-th matching ratio update.
- err asserts the cycle after per_cnt reaches MAX_RATIO.
- First valid after start for divide-by-N: STABLE_N+1 rises after lock, i.e. ≈ (STABLE_N+1)·N + 2 cycles.
- Asynchronous reset clears all outputs immediately, mid-measurement included.

## Configuration
- DIV_METER_DUTY_EN defined: high-time counter present; high_cnt reports high time; stability additionally requires high_cnt equal to previous.
- Undefined: high-time counter removed; high_cnt tied to 0; stability on period only.

## Structure
- Shared package div_meter_pkg: state enum (IDLE, SYNC, MEASURE), default CNT_W/MAX_RATIO constants.
- One sub-module: div_edge_det (registered div_in, rise output), reusable by other clock checkers.

## Test plan
- Reset held, then start with div_in = clk_div2 → ratio=2, high_cnt=1, valid=1 after 3 rises, err=0.
- div_in = clk_div4 (2 high/2 low) → ratio=4, high_cnt=2, valid=1.
- div_in = clk_div6, switch to clk_div8 mid-run → valid drops on first period 8, re-asserts with ratio=8 after STABLE_N periods.
- div_in held 0 after start, MAX_RATIO=20 → err=1 21 cycles after start, valid=0; new start clears err.
- reset pulse low during MEASURE with clk_div3 → all outputs 0 immediately; after release and start, ratio=3.
- Without DIV_METER_DUTY_EN, clk_div4 → ratio=4, high_cnt=0, valid=1.
